// File: rtl/residual_ram_reader_if.sv
// ----------------------------------------------------------------------------
// residual_ram_reader_if
//
// Groups the control, RAM read-port and output-stream signals of
// residual_ram_reader. The clock and the asynchronous reset stay plain ports
// on the module itself.
//
// Signal summary:
//   iStart, iBaseAddr, iBlockSize   block request (sampled only while idle)
//   oRdAddr, oRdEn, iRamQ           residual RAM read port
//   oData, oValid, iReady, oLast    sample stream towards the Rice encoder
//   oBusy, oDone                    block status
//   oDbgState, oDbgFifoCount,
//   oDbgInflight                    debug visibility of FSM state and credits
//
// Modports:
//   master  the reader block (drives o*, samples i*)
//   slave   the surroundings: RAM, controller and consumer
// ----------------------------------------------------------------------------
interface residual_ram_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
);
    // control
    logic              iStart;
    logic [ADDR_W-1:0] iBaseAddr;
    logic [ADDR_W-1:0] iBlockSize;

    // RAM read port
    logic [ADDR_W-1:0] oRdAddr;
    logic              oRdEn;
    logic [DATA_W-1:0] iRamQ;

    // Output stream. Valid/ready: a word moves when oValid and iReady are
    // both high on a rising edge; once oValid is raised, oData/oLast/oValid
    // hold steady until that transfer happens, and oValid never waits on
    // iReady.
    logic [DATA_W-1:0] oData;
    logic              oValid;
    logic              iReady;
    logic              oLast;

    // status
    logic              oBusy;
    logic              oDone;

    // debug
    logic [1:0]        oDbgState;
    logic [7:0]        oDbgFifoCount;
    logic [7:0]        oDbgInflight;

    modport master (
        input  iStart, iBaseAddr, iBlockSize,
        output oRdAddr, oRdEn,
        input  iRamQ,
        output oData, oValid, oLast,
        input  iReady,
        output oBusy, oDone,
        output oDbgState, oDbgFifoCount, oDbgInflight
    );

    modport slave (
        output iStart, iBaseAddr, iBlockSize,
        input  oRdAddr, oRdEn,
        output iRamQ,
        input  oData, oValid, oLast,
        output iReady,
        input  oBusy, oDone,
        input  oDbgState, oDbgFifoCount, oDbgInflight
    );
endinterface

// File: rtl/residual_ram_reader.sv
// ----------------------------------------------------------------------------
// residual_ram_reader
//
// Streams a block of residual samples out of the residual RAM towards the
// Rice encoder. The block issues its own RAM reads, follows each read
// through the RAM latency with a tag shift register and lands the returning
// word in a small output FIFO. Reads are only issued while the FIFO is sure
// to have room for every word still in flight, so back-pressure from the
// consumer can never overflow the FIFO, and with iReady held high one sample
// leaves per clock.
//
// Ports:
//   iClock    clock, rising edge
//   iReset_n  asynchronous active-low reset
//   bus       residual_ram_reader_if.master (control, RAM port, stream,
//             status, debug)
//
// Parameters:
//   DATA_W      sample width
//   ADDR_W      RAM address width (addresses wrap modulo 2^ADDR_W)
//   READ_LAT    RAM address-to-q latency, 1 or 2 cycles
//   FIFO_DEPTH  output FIFO entries; READ_LAT+2 is the smallest depth that
//               sustains one sample per clock
// ----------------------------------------------------------------------------
module residual_ram_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 13,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = READ_LAT + 2
) (
    input  logic                 iClock,
    input  logic                 iReset_n,
    residual_ram_reader_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    // block registers
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] size_q;
    logic [ADDR_W-1:0] issued_q;

    // read tracking: one {valid, last} tag per pipeline stage of the RAM
    logic [READ_LAT-1:0] tag_valid;
    logic [READ_LAT-1:0] tag_last;
    logic [CNT_W-1:0]    inflight;

    // output FIFO
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              done_q;

    // combinational control
    logic              credit_ok;
    logic              rd_en;
    logic              rd_last;
    logic              latch_block;
    logic              done_next;
    logic              push;
    logic              push_last;
    logic              pop;
    logic              fifo_empty;
    logic              head_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Credit accounting. Every valid tag is a word that will be pushed
    // without any chance of being refused, so a read may only start when
    // the words already stored plus those still inside the RAM leave a
    // free slot. A pop in the same cycle is deliberately not credited:
    // the freed slot becomes usable one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_valid[i]);
        end
    end

    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < SUM_W'(FIFO_DEPTH);

    // A tag leaving the last stage means iRamQ holds its word right now.
    assign push      = tag_valid[READ_LAT-1];
    assign push_last = tag_last[READ_LAT-1];

    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && bus.iReady;
    assign head_last  = fifo_last[rd_ptr];

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        rd_en       = 1'b0;
        rd_last     = 1'b0;
        latch_block = 1'b0;
        done_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.iStart) begin
                    if (bus.iBlockSize != '0) begin
                        latch_block = 1'b1;
                        state_next  = ST_RUN;
                    end else begin
                        // empty block: nothing to read, just report completion
                        done_next = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (credit_ok) begin
                    rd_en   = 1'b1;
                    // size_q is never zero here, so size_q-1 is the final index
                    rd_last = (issued_q == size_q - ADDR_W'(1));
                    if (rd_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The last-flagged word is by construction the final thing in
                // flight, so its transfer means the RAM pipe and FIFO are empty.
                if (pop && head_last) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state, block registers, tag pipeline, FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            size_q     <= '0;
            issued_q   <= '0;
            tag_valid  <= '0;
            tag_last   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;

            if (latch_block) begin
                base_q   <= bus.iBaseAddr;
                size_q   <= bus.iBlockSize;
                issued_q <= '0;
            end else if (rd_en) begin
                issued_q <= issued_q + ADDR_W'(1);
            end

            tag_valid[0] <= rd_en;
            tag_last[0]  <= rd_last;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage needs no reset: nothing is ever read from a slot that
    // has not been written since the pointers were cleared.
    always_ff @(posedge iClock) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.iRamQ;
            fifo_last[wr_ptr] <= push_last;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The address is an ADDR_W-bit sum, so running past the top of the RAM
    // wraps to address 0 for free.
    assign bus.oRdAddr = base_q + issued_q;
    assign bus.oRdEn   = rd_en;

    // Stream outputs are forced to zero while empty so that stale FIFO
    // contents never show up on the bus.
    assign bus.oValid  = !fifo_empty;
    assign bus.oData   = fifo_empty ? '0 : fifo_data[rd_ptr];
    assign bus.oLast   = fifo_empty ? 1'b0 : head_last;

    assign bus.oBusy   = (state != ST_IDLE);
    assign bus.oDone   = done_q;

    assign bus.oDbgState     = state;
    assign bus.oDbgFifoCount = 8'(fifo_count);
    assign bus.oDbgInflight  = 8'(inflight);

endmodule

// File: tb/tb_residual_ram_reader.sv
// ----------------------------------------------------------------------------
// tb_residual_ram_reader
//
// Bench for residual_ram_reader with a two-cycle registered RAM model. Every
// block request pushes the expected words ({last, data}) and expected read
// addresses into queues; a negedge monitor pops and compares them as the DUT
// issues reads and transfers words, and also watches the stall-hold rule,
// the credit bound and the oDone pulse.
// ----------------------------------------------------------------------------
module tb_residual_ram_reader;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 13;
    localparam int READ_LAT   = 2;
    localparam int FIFO_DEPTH = READ_LAT + 2;
    localparam int RAM_N      = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    residual_ram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    residual_ram_reader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .READ_LAT  (READ_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .iClock  (clk),
        .iReset_n(rst_n),
        .bus     (bus)
    );

    // ---------------- RAM model: address register + output register ----------------
    logic [DATA_W-1:0] ram [RAM_N];
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_q;

    always @(posedge clk) begin
        ram_addr_q <= bus.oRdAddr;
        ram_q      <= ram[ram_addr_q];
    end
    assign bus.iRamQ = ram_q;

    // ---------------- scoreboard state ----------------
    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int start_cyc       = 0;
    int first_valid_rel = -1;
    int last_rel        = -1;
    int done_rel        = -1;
    int done_cnt        = 0;
    int xfer_cnt        = 0;
    int rd_cnt          = 0;
    bit done_seen       = 1'b0;
    bit busy_seen       = 1'b0;
    bit stall_prev      = 1'b0;
    logic [DATA_W:0] stall_word;

    int ready_mode  = 0;
    int ready_phase = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- consumer ready driver ----------------
    // mode 0: always ready; mode 1: 1,0,0,1 repeating; mode 2: random
    initial begin
        bus.iReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_phase++;
            case (ready_mode)
                0:       bus.iReady = 1'b1;
                1:       bus.iReady = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
                default: bus.iReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            int              rel;
            logic [DATA_W:0] got;
            logic [DATA_W:0] e;
            logic            credit_ok;

            rel = cyc - start_cyc + 1;

            if (bus.oBusy) busy_seen = 1'b1;
            if (bus.oValid && first_valid_rel < 0) first_valid_rel = rel;

            credit_ok = (bus.oDbgFifoCount + bus.oDbgInflight) <= 8'(FIFO_DEPTH);
            check("credit_bound", 32'(credit_ok), 32'd1);

            got = {bus.oLast, bus.oData};
            if (stall_prev) begin
                check("stall_valid", 32'(bus.oValid), 32'd1);
                check("stall_hold", 32'(got), 32'(stall_word));
            end
            stall_prev = bus.oValid && !bus.iReady;
            stall_word = got;

            if (bus.oRdEn) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0)
                    check("rd_unexpected", 32'(bus.oRdAddr), 32'hFFFF_FFFF);
                else
                    check("rd_addr", 32'(bus.oRdAddr), 32'(exp_addr_q.pop_front()));
            end

            if (bus.oValid && bus.iReady) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_word", 32'(got), 32'(e));
                end
                if (bus.oLast) last_rel = rel;
            end

            if (bus.oDone) begin
                done_cnt++;
                done_seen = 1'b1;
                done_rel  = rel;
                check("busy_at_done", 32'(bus.oBusy), 32'd0);
                check("state_at_done", 32'(bus.oDbgState), 32'd0);
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_block(input int base, input int size);
        logic lb;
        int   a;
        for (int i = 0; i < size; i++) begin
            a  = (base + i) % RAM_N;
            lb = (i == size - 1);
            exp_q.push_back({lb, ram[a]});
            exp_addr_q.push_back(ADDR_W'(a));
        end
        first_valid_rel = -1;
        last_rel        = -1;
        done_rel        = -1;
        done_seen       = 1'b0;
        done_cnt        = 0;
        xfer_cnt        = 0;
        rd_cnt          = 0;
        busy_seen       = 1'b0;
        @(posedge clk);
        #1;
        bus.iStart     = 1'b1;
        bus.iBaseAddr  = ADDR_W'(base);
        bus.iBlockSize = ADDR_W'(size);
        @(posedge clk);              // E0: iStart sampled here
        #1;
        start_cyc  = cyc;            // we are now in cycle 1
        bus.iStart = 1'b0;
    endtask

    // exp_done < 0 skips the cycle-exact timing checks (stalling consumer)
    task automatic run_block(input int base, input int size, input int exp_done, input bit mid_start);
        int n;
        start_block(base, size);
        n = 0;
        while (!done_seen && n < size * 4 + 50) begin
            @(negedge clk);
            n++;
            if (mid_start && n == 6) begin
                bus.iStart     = 1'b1;
                bus.iBaseAddr  = ADDR_W'(100);
                bus.iBlockSize = ADDR_W'(3);
            end
            if (mid_start && n == 7) bus.iStart = 1'b0;
        end
        bus.iStart = 1'b0;
        check("done_seen", 32'(done_seen), 32'd1);
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("xfer_count", 32'(xfer_cnt), 32'(size));
        check("read_count", 32'(rd_cnt), 32'(size));
        check("exp_q_left", 32'(exp_q.size()), 32'd0);
        check("busy_seen", 32'(busy_seen), 32'(size != 0));
        if (exp_done >= 0) begin
            check("done_cycle", 32'(done_rel), 32'(exp_done));
            if (size > 0) begin
                check("first_valid_cycle", 32'(first_valid_rel), 32'(READ_LAT + 2));
                check("last_cycle", 32'(last_rel), 32'(1 + READ_LAT + size));
            end
        end
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdaddr"}, 32'(bus.oRdAddr), 32'd0);
        check({tag, "_rden"},   32'(bus.oRdEn),   32'd0);
        check({tag, "_data"},   32'(bus.oData),   32'd0);
        check({tag, "_valid"},  32'(bus.oValid),  32'd0);
        check({tag, "_last"},   32'(bus.oLast),   32'd0);
        check({tag, "_busy"},   32'(bus.oBusy),   32'd0);
        check({tag, "_done"},   32'(bus.oDone),   32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bus.iStart     = 1'b0;
        bus.iBaseAddr  = '0;
        bus.iBlockSize = '0;
        for (int i = 0; i < RAM_N; i++) ram[i] = DATA_W'(i);

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full-size block, consumer always ready: exact timing
        ready_mode = 0;
        run_block(0, 4096, 2 + READ_LAT + 4096, 1'b0);

        // address wrap at the top of the RAM
        run_block(8190, 4, 2 + READ_LAT + 4, 1'b0);

        // stalling consumer 1,0,0,1
        ready_mode = 1;
        run_block(16, 8, -1, 1'b0);

        // empty block
        ready_mode = 0;
        run_block(0, 0, 1, 1'b0);

        // iStart during a block is ignored; original size and timing kept
        run_block(200, 20, 2 + READ_LAT + 20, 1'b1);

        // reset in the middle of a block
        start_block(500, 200);
        n = 0;
        while (xfer_cnt < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_sample_100", 32'(xfer_cnt >= 100), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_block(50, 2, 2 + READ_LAT + 2, 1'b0);

        // random consumer, random blocks
        ready_mode = 2;
        for (int k = 0; k < 3; k++) begin
            run_block(int'($urandom_range(0, RAM_N - 1)), int'($urandom_range(1, 40)), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // hard stop in case the sequence itself stalls
    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
